max_unpool: RTL and testbench

//  Inverse of the max-reduction stage: takes a {max value, argmax index} pair and

---
 rtl/max_unpool.sv | 108 ++++++++++
 tb/tb_max_unpool.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_unpool.sv
// max_unpool: scatters a {value, argmax index} pair into a pOUTPUT_NUM-lane vector.
// Every lane other than the indexed one receives the fill value.
// Elastic two-stage pipeline (decode register, output register) with valid/ready on both sides.
module max_unpool #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pOUTPUT_NUM = 32,
  parameter int unsigned pFILL_MIN   = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [pDATA_WIDTH-1:0]               in_data,
  input  logic [$clog2(pOUTPUT_NUM)-1:0]       in_index,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [pDATA_WIDTH*pOUTPUT_NUM-1:0]   out_data,
  output logic [pOUTPUT_NUM-1:0]               out_mask,
  output logic                                 err_range,
  output logic [15:0]                          err_count
);

  localparam int unsigned IDXW  = $clog2(pOUTPUT_NUM);
  localparam int unsigned IDXW1 = IDXW + 1;
  localparam int unsigned VECW  = pDATA_WIDTH * pOUTPUT_NUM;
  localparam logic [IDXW1-1:0] LANES = IDXW1'(pOUTPUT_NUM);
  localparam logic [pDATA_WIDTH-1:0] FILL =
    (pFILL_MIN != 0) ? {1'b1, {(pDATA_WIDTH-1){1'b0}}} : {pDATA_WIDTH{1'b0}};

  // Decode stage register
  logic                   s1_valid;
  logic [pDATA_WIDTH-1:0] s1_data;
  logic [IDXW-1:0]        s1_index;
  logic                   s1_oor;

  logic                   s2_load;
  logic                   in_fire;
  logic                   in_oor;
  logic [VECW-1:0]        s2_data_c;
  logic [pOUTPUT_NUM-1:0] s2_mask_c;

  // Handshake: each stage loads when empty or when its content moves on this cycle
  always_comb begin
    s2_load  = !out_valid || out_ready;
    in_ready = !s1_valid || s2_load;
    in_fire  = in_valid && in_ready;
    in_oor   = {1'b0, in_index} >= LANES;
  end

  // Decode stage: capture value, index and out-of-range flag
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_index <= '0;
      s1_oor   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data  <= in_data;
        s1_index <= in_index;
        s1_oor   <= in_oor;
      end
    end
  end

  // Range error tracking, updated as the pair enters the decode stage
  always_ff @(posedge clk) begin
    if (rst) begin
      err_range <= 1'b0;
      err_count <= '0;
    end else if (in_fire && in_oor) begin
      err_range <= 1'b1;
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

  // Expand the decoded pair into the lane vector and one-hot mask
  always_comb begin
    s2_data_c = '0;
    s2_mask_c = '0;
    for (int unsigned i = 0; i < pOUTPUT_NUM; i++) begin
      s2_data_c[i*pDATA_WIDTH +: pDATA_WIDTH] = FILL;
      if (!s1_oor && (s1_index == IDXW'(i))) begin
        s2_data_c[i*pDATA_WIDTH +: pDATA_WIDTH] = s1_data;
        s2_mask_c[i] = 1'b1;
      end
    end
  end

  // Output stage: holds the beat stable while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_data_c;
        out_mask <= s2_mask_c;
      end
    end
  end

endmodule

// File: tb/tb_max_unpool.sv
// tb_max_unpool: directed bench for max_unpool.
// Instance a: 32 lanes, zero fill. Instance b: 5 lanes, most-negative fill.
module tb_max_unpool;

  localparam int unsigned DW = 32;
  localparam int unsigned NA = 32;
  localparam int unsigned NB = 5;

  typedef struct packed {
    logic [31:0] val;
    logic [4:0]  idx;
  } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0]    a_in_data;
  logic [4:0]       a_in_index;
  logic [DW*NA-1:0] a_out_data;
  logic [NA-1:0]    a_out_mask;
  logic             a_err_range;
  logic [15:0]      a_err_count;

  logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0]    b_in_data;
  logic [2:0]       b_in_index;
  logic [DW*NB-1:0] b_out_data;
  logic [NB-1:0]    b_out_mask;
  logic             b_err_range;
  logic [15:0]      b_err_count;

  max_unpool #(.pDATA_WIDTH(DW), .pOUTPUT_NUM(NA), .pFILL_MIN(0)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_index(a_in_index),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_mask(a_out_mask),
    .err_range(a_err_range), .err_count(a_err_count)
  );

  max_unpool #(.pDATA_WIDTH(DW), .pOUTPUT_NUM(NB), .pFILL_MIN(1)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_index(b_in_index),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_mask(b_out_mask),
    .err_range(b_err_range), .err_count(b_err_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream ready for instance a: fixed level or random
  logic rand_en    = 1'b0;
  logic ready_lvl  = 1'b1;
  initial begin
    a_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      a_out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_lvl;
    end
  end

  pair_t exp_q[$];

  // Output monitor for instance a: scoreboard, hold-while-stalled and run length
  logic             hold_prev = 1'b0;
  logic [DW*NA-1:0] prev_data = '0;
  logic [NA-1:0]    prev_mask = '0;
  logic             prev_beat = 1'b0;
  int               run_len   = 0;

  always @(negedge clk) begin : mon_a
    pair_t       e;
    logic [31:0] lane_exp;
    logic        beat;
    beat = a_out_valid && a_out_ready;
    if (rst) begin
      hold_prev <= 1'b0;
      prev_beat <= 1'b0;
    end else begin
      if (hold_prev) begin
        check("a_hold_valid", 64'(a_out_valid), 64'd1);
        check("a_hold_mask", 64'(a_out_mask), 64'(prev_mask));
        check("a_hold_data_same", 64'(a_out_data == prev_data), 64'd1);
      end
      hold_prev <= a_out_valid && !a_out_ready;
      prev_data <= a_out_data;
      prev_mask <= a_out_mask;
      prev_beat <= beat;
      if (beat) begin
        run_len <= prev_beat ? run_len + 1 : 1;
        if (exp_q.size() == 0) begin
          check("a_extra_beat", 64'(beat), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("a_mask", 64'(a_out_mask), 64'(32'd1 << e.idx));
          for (int i = 0; i < int'(NA); i++) begin
            lane_exp = (i == int'(e.idx)) ? e.val : 32'd0;
            check("a_lane", 64'(a_out_data[i*DW +: DW]), 64'(lane_exp));
          end
        end
      end
    end
  end

  task automatic send_a(input logic [31:0] v, input logic [4:0] idx, output int tries);
    logic  acc;
    pair_t p;
    acc   = 1'b0;
    tries = 0;
    a_in_valid = 1'b1;
    a_in_data  = v;
    a_in_index = idx;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = a_in_ready;
      tries++;
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
    if (acc) begin
      p.val = v;
      p.idx = idx;
      exp_q.push_back(p);
    end else begin
      check("a_send_timeout", 64'(acc), 64'd1);
    end
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("a_drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic b_expect(input string tag, input logic [31:0] v, input int idx);
    int          n;
    logic [31:0] lane_exp;
    logic [NB-1:0] mask_exp;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_out_valid && n < 20);
    check({tag, "_valid"}, 64'(b_out_valid), 64'd1);
    mask_exp = (idx < int'(NB)) ? NB'(1 << idx) : '0;
    check({tag, "_mask"}, 64'(b_out_mask), 64'(mask_exp));
    for (int i = 0; i < int'(NB); i++) begin
      lane_exp = (i == idx) ? v : 32'h8000_0000;
      check({tag, "_lane"}, 64'(b_out_data[i*DW +: DW]), 64'(lane_exp));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_index = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_index = '0;
    b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_a_mask", 64'(a_out_mask), 64'd0);
    check("rst_a_data_nonzero", 64'(a_out_data != '0), 64'd0);
    check("rst_b_err_range", 64'(b_err_range), 64'd0);
    check("rst_b_err_count", 64'(b_err_count), 64'd0);
    @(posedge clk);
    #1;

    // Single pair (-7, 3): output two edges after it is offered
    send_a(32'hFFFF_FFF9, 5'd3, tries);
    check("t1_tries", 64'(tries), 64'd1);
    @(negedge clk);
    check("t1_valid_early", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    check("t1_valid", 64'(a_out_valid), 64'd1);
    check("t1_lane3", 64'(a_out_data[3*DW +: DW]), 64'h0000_0000_FFFF_FFF9);
    check("t1_mask", 64'(a_out_mask), 64'h0000_0000_0000_0008);
    @(posedge clk);
    #1;
    drain_a();

    // Back-to-back indices 0..31: no bubbles, in_ready never drops
    for (int k = 0; k < 32; k++) begin
      send_a(32'(k + 100), 5'(k), tries);
      check("t2_in_ready_first_try", 64'(tries), 64'd1);
    end
    drain_a();
    check("t2_run_len", 64'(run_len), 64'd32);

    // Random backpressure over 10 pairs
    rand_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send_a(32'hA000_0000 + 32'(k), 5'((k * 7) % 32), tries);
    end
    rand_en = 1'b0;
    ready_lvl = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drain_a();

    // Instance b: in-range then out-of-range index
    b_in_valid = 1'b1; b_in_data = 32'h1234_5678; b_in_index = 3'd4;
    @(posedge clk);
    #1;
    b_in_data = 32'h0000_0055; b_in_index = 3'd6;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_expect("t4_beat1", 32'h1234_5678, 4);
    b_expect("t4_beat2", 32'h0000_0055, 6);
    check("t4_err_range", 64'(b_err_range), 64'd1);
    check("t4_err_count", 64'(b_err_count), 64'd1);
    @(posedge clk);
    #1;

    // Fill the pipe under stall, then reset mid-flight
    ready_lvl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_a(32'd10, 5'd1, tries);
    send_a(32'd20, 5'd2, tries);
    a_in_valid = 1'b1; a_in_data = 32'd30; a_in_index = 5'd5;
    @(negedge clk);
    check("t5_in_ready_full", 64'(a_in_ready), 64'd0);
    check("t5_out_valid_full", 64'(a_out_valid), 64'd1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_out_valid", 64'(a_out_valid), 64'd0);
    check("t5_in_ready", 64'(a_in_ready), 64'd1);
    check("t5_mask", 64'(a_out_mask), 64'd0);
    check("t5_data_nonzero", 64'(a_out_data != '0), 64'd0);
    check("t5_b_err_range", 64'(b_err_range), 64'd0);
    check("t5_b_err_count", 64'(b_err_count), 64'd0);
    ready_lvl = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_no_stale_beat", 64'(a_out_valid), 64'd0);
    @(posedge clk);
    #1;
    send_a(32'h7FFF_FFFF, 5'd31, tries);
    drain_a();

    // Saturating error counter on instance b
    b_in_valid = 1'b1; b_in_data = 32'h0000_0001; b_in_index = 3'd7;
    repeat (65534) @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_count_fffe", 64'(b_err_count), 64'h0000_0000_0000_FFFE);
    @(posedge clk);
    #1;
    b_in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_count_sat", 64'(b_err_count), 64'h0000_0000_0000_FFFF);
    check("t6_err_range", 64'(b_err_range), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
